// File: rtl/ctrl_pipe.sv
// Control pipeline: carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB,
// and produces the load-use stall, EX forwarding selects and the retired-instruction count.
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             RegDst_i,
  input  logic             ALUSrc_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic [4:0]       rd_i,
  output logic             stall_o,
  output logic             ex_RegDst_o,
  output logic             ex_ALUSrc_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_wreg_o,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic             mem_MemRead_o,
  output logic             mem_MemWrite_o,
  output logic [4:0]       mem_wreg_o,
  output logic             wb_RegWrite_o,
  output logic             wb_MemtoReg_o,
  output logic [4:0]       wb_wreg_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef struct packed {
    logic       valid;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } mem_wb_t;

  id_ex_t          id_ex, id_ex_next;
  ex_mem_t         ex_mem, ex_mem_next;
  mem_wb_t         mem_wb, mem_wb_next;
  logic [CNT_W-1:0] retired;
  logic            bubble;

  // Load-use hazard: the load in EX produces a register the instruction in ID reads.
  always_comb begin
    stall_o = id_ex.valid && id_ex.mem_read && (id_ex.rt != 5'd0) && valid_i &&
              ((id_ex.rt == rs_i) || (id_ex.rt == rt_i));
    bubble  = stall_o || flush_i || !valid_i;
  end

  always_comb begin
    id_ex_next            = '0;
    if (!bubble) begin
      id_ex_next.valid      = 1'b1;
      id_ex_next.reg_dst    = RegDst_i;
      id_ex_next.alu_src    = ALUSrc_i;
      id_ex_next.alu_op     = ALUOp_i;
      id_ex_next.mem_read   = MemRead_i;
      id_ex_next.mem_write  = MemWrite_i;
      id_ex_next.reg_write  = RegWrite_i;
      id_ex_next.mem_to_reg = MemtoReg_i;
      id_ex_next.rs         = rs_i;
      id_ex_next.rt         = rt_i;
      id_ex_next.wreg       = RegDst_i ? rd_i : rt_i;
    end

    ex_mem_next.valid      = id_ex.valid;
    ex_mem_next.mem_read   = id_ex.mem_read;
    ex_mem_next.mem_write  = id_ex.mem_write;
    ex_mem_next.reg_write  = id_ex.reg_write;
    ex_mem_next.mem_to_reg = id_ex.mem_to_reg;
    ex_mem_next.wreg       = id_ex.wreg;

    mem_wb_next.valid      = ex_mem.valid;
    mem_wb_next.reg_write  = ex_mem.reg_write;
    mem_wb_next.mem_to_reg = ex_mem.mem_to_reg;
    mem_wb_next.wreg       = ex_mem.wreg;
  end

  // Hold freezes every stage and the counter; otherwise all stages advance together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_ex   <= '0;
      ex_mem  <= '0;
      mem_wb  <= '0;
      retired <= '0;
    end else if (!hold_i) begin
      id_ex  <= id_ex_next;
      ex_mem <= ex_mem_next;
      mem_wb <= mem_wb_next;
      if (mem_wb.valid) retired <= retired + CNT_W'(1);
    end
  end

  // The nearer producer (EX/MEM) wins; $0 never forwards.
  always_comb begin
    ForwardA_o = 2'b00;
    ForwardB_o = 2'b00;
    if (ex_mem.valid && ex_mem.reg_write && (ex_mem.wreg != 5'd0) && (ex_mem.wreg == id_ex.rs))
      ForwardA_o = 2'b10;
    else if (mem_wb.valid && mem_wb.reg_write && (mem_wb.wreg != 5'd0) && (mem_wb.wreg == id_ex.rs))
      ForwardA_o = 2'b01;
    if (ex_mem.valid && ex_mem.reg_write && (ex_mem.wreg != 5'd0) && (ex_mem.wreg == id_ex.rt))
      ForwardB_o = 2'b10;
    else if (mem_wb.valid && mem_wb.reg_write && (mem_wb.wreg != 5'd0) && (mem_wb.wreg == id_ex.rt))
      ForwardB_o = 2'b01;
  end

  always_comb begin
    ex_RegDst_o    = id_ex.reg_dst;
    ex_ALUSrc_o    = id_ex.alu_src;
    ex_ALUOp_o     = id_ex.alu_op;
    ex_rs_o        = id_ex.rs;
    ex_rt_o        = id_ex.rt;
    ex_wreg_o      = id_ex.wreg;
    mem_MemRead_o  = ex_mem.mem_read;
    mem_MemWrite_o = ex_mem.mem_write;
    mem_wreg_o     = ex_mem.wreg;
    wb_RegWrite_o  = mem_wb.reg_write;
    wb_MemtoReg_o  = mem_wb.mem_to_reg;
    wb_wreg_o      = mem_wb.wreg;
    retired_o      = retired;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed vector table for the hazard/forward/hold corners, then
// randomized traffic checked against an instruction-level pipeline model.
module tb_ctrl_pipe;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             hold_i, flush_i, valid_i;
  logic             RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [1:0]       ALUOp_i;
  logic [4:0]       rs_i, rt_i, rd_i;
  logic             stall_o, ex_RegDst_o, ex_ALUSrc_o;
  logic [1:0]       ex_ALUOp_o, ForwardA_o, ForwardB_o;
  logic [4:0]       ex_rs_o, ex_rt_o, ex_wreg_o, mem_wreg_o, wb_wreg_o;
  logic             mem_MemRead_o, mem_MemWrite_o, wb_RegWrite_o, wb_MemtoReg_o;
  logic [CNT_W-1:0] retired_o;

  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .ALUOp_i(ALUOp_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .stall_o(stall_o),
    .ex_RegDst_o(ex_RegDst_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_ALUOp_o(ex_ALUOp_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_wreg_o(ex_wreg_o),
    .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
    .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o), .mem_wreg_o(mem_wreg_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o), .wb_wreg_o(wb_wreg_o),
    .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       valid;
    logic       reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0] alu_op;
    logic [4:0] rs, rt, rd;
  } in_t;

  typedef struct packed {
    logic       valid;
    logic       reg_dst, alu_src;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, reg_write, mem_to_reg;
    logic [4:0] rs, rt, wreg;
  } instr_t;

  typedef struct packed {
    in_t        vin;
    logic       hold, flush;
    logic       stall;
    logic [1:0] fa, fb;
    logic [4:0] ex_wreg;
    logic       mem_mw, wb_rw;
    logic [4:0] wb_wreg;
    logic [3:0] ret;
  } row_t;

  localparam int NOP = 0, ADD = 1, LW = 2, SW = 3;

  int               checks = 0;
  int               passes = 0;
  in_t              cur_in;
  logic             cur_hold, cur_flush;
  instr_t           pipe [3];
  logic [CNT_W-1:0] m_retired;
  row_t             rows [$];

  function automatic in_t mk(int kind, int rs, int rt, int rd);
    in_t v = '0;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
    case (kind)
      ADD: begin v.valid = 1; v.reg_dst = 1; v.reg_write = 1; v.alu_op = 2'b11; end
      LW:  begin v.valid = 1; v.alu_src = 1; v.mem_read = 1; v.reg_write = 1; v.mem_to_reg = 1; end
      SW:  begin v.valid = 1; v.alu_src = 1; v.mem_write = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Instruction-level model: three slots hold whole instructions as they move EX -> MEM -> WB.
  function automatic logic model_stall();
    return pipe[0].valid && pipe[0].mem_read && pipe[0].rt != 0 && cur_in.valid &&
           (pipe[0].rt == cur_in.rs || pipe[0].rt == cur_in.rt);
  endfunction

  function automatic logic [1:0] model_fwd(logic [4:0] src);
    if (src == 0) return 2'b00;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].valid && pipe[s].reg_write && pipe[s].wreg == src)
        return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    m_retired = '0;
  endtask

  task automatic model_step();
    logic stall_now;
    instr_t n;
    stall_now = model_stall();
    if (cur_hold) return;
    if (pipe[2].valid) m_retired++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    n = '0;
    if (!stall_now && !cur_flush && cur_in.valid) begin
      n.valid = 1; n.reg_dst = cur_in.reg_dst; n.alu_src = cur_in.alu_src;
      n.alu_op = cur_in.alu_op; n.mem_read = cur_in.mem_read; n.mem_write = cur_in.mem_write;
      n.reg_write = cur_in.reg_write; n.mem_to_reg = cur_in.mem_to_reg;
      n.rs = cur_in.rs; n.rt = cur_in.rt;
      n.wreg = cur_in.reg_dst ? cur_in.rd : cur_in.rt;
    end
    pipe[0] = n;
  endtask

  task automatic applyStimulus(in_t v, logic hold, logic flush);
    cur_in = v; cur_hold = hold; cur_flush = flush;
    hold_i = hold; flush_i = flush; valid_i = v.valid;
    RegDst_i = v.reg_dst; ALUSrc_i = v.alu_src; MemRead_i = v.mem_read;
    MemWrite_i = v.mem_write; RegWrite_i = v.reg_write; MemtoReg_i = v.mem_to_reg;
    ALUOp_i = v.alu_op; rs_i = v.rs; rt_i = v.rt; rd_i = v.rd;
  endtask

  task automatic checkOutput();
    check("stall", 32'(stall_o), 32'(model_stall()));
    check("ex_bundle", 32'({ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, ex_rs_o, ex_rt_o, ex_wreg_o}),
          32'({pipe[0].reg_dst, pipe[0].alu_src, pipe[0].alu_op, pipe[0].rs, pipe[0].rt, pipe[0].wreg}));
    check("forward", 32'({ForwardA_o, ForwardB_o}),
          32'({model_fwd(pipe[0].rs), model_fwd(pipe[0].rt)}));
    check("mem_bundle", 32'({mem_MemRead_o, mem_MemWrite_o, mem_wreg_o}),
          32'({pipe[1].mem_read, pipe[1].mem_write, pipe[1].wreg}));
    check("wb_bundle", 32'({wb_RegWrite_o, wb_MemtoReg_o, wb_wreg_o}),
          32'({pipe[2].reg_write, pipe[2].mem_to_reg, pipe[2].wreg}));
    check("retired", 32'(retired_o), 32'(m_retired));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_outs"}, 32'({stall_o, ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, ex_rs_o, ex_rt_o,
                               ex_wreg_o, ForwardA_o, ForwardB_o}), 32'd0);
    check({tag, "_late"}, 32'({mem_MemRead_o, mem_MemWrite_o, mem_wreg_o, wb_RegWrite_o,
                               wb_MemtoReg_o, wb_wreg_o, retired_o}), 32'd0);
  endtask

  task automatic cycle();
    #1 checkOutput();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic add_row(in_t v, logic h, logic f, logic st, logic [1:0] fa, logic [1:0] fb,
                         logic [4:0] exw, logic mmw, logic wrw, logic [4:0] wbw, logic [3:0] ret);
    row_t r;
    r.vin = v; r.hold = h; r.flush = f; r.stall = st; r.fa = fa; r.fb = fb;
    r.ex_wreg = exw; r.mem_mw = mmw; r.wb_rw = wrw; r.wb_wreg = wbw; r.ret = ret;
    rows.push_back(r);
  endtask

  initial begin
    in_t  v;
    logic keep;

    // Hand-derived expectations; each row is what is observed before that row's clock edge.
    add_row(mk(ADD,1,2,8), 0,0, 0,2'b00,2'b00, 8'd0,  0,0, 5'd0, 4'd0);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd8,  0,0, 5'd0, 4'd0);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd0);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd8, 4'd0);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd1);
    add_row(mk(LW,1,9,0),  0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd1);
    add_row(mk(ADD,9,3,10),0,0, 1,2'b00,2'b00, 5'd9,  0,0, 5'd0, 4'd1);
    add_row(mk(ADD,9,3,10),0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd1);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b01,2'b00, 5'd10, 0,1, 5'd9, 4'd1);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd2);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd10,4'd2);
    add_row(mk(ADD,1,2,5), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd3);
    add_row(mk(ADD,1,2,5), 0,0, 0,2'b00,2'b00, 5'd5,  0,0, 5'd0, 4'd3);
    add_row(mk(ADD,5,5,6), 0,0, 0,2'b00,2'b00, 5'd5,  0,0, 5'd0, 4'd3);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b10,2'b10, 5'd6,  0,1, 5'd5, 4'd3);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd5, 4'd4);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd6, 4'd5);
    add_row(mk(ADD,1,2,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd6);
    add_row(mk(ADD,1,2,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd6);
    add_row(mk(ADD,0,0,7), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd6);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd7,  0,1, 5'd0, 4'd6);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd0, 4'd7);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd7, 4'd8);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd9);
    add_row(mk(SW,1,2,0),  0,1, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd9);
    add_row(mk(SW,1,2,0),  0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd2,  0,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 1,0, 0,2'b00,2'b00, 5'd0,  1,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 1,0, 0,2'b00,2'b00, 5'd0,  1,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 1,0, 0,2'b00,2'b00, 5'd0,  1,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  1,0, 5'd0, 4'd9);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd2, 4'd9);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd10);
    add_row(mk(LW,1,4,0),  0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd10);
    add_row(mk(ADD,4,4,11),0,1, 1,2'b00,2'b00, 5'd4,  0,0, 5'd0, 4'd10);
    add_row(mk(ADD,2,3,12),0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd10);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd12, 0,1, 5'd4, 4'd10);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd11);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,1, 5'd12,4'd11);
    add_row(mk(NOP,0,0,0), 0,0, 0,2'b00,2'b00, 5'd0,  0,0, 5'd0, 4'd12);

    rst_i = 1'b0;
    applyStimulus(mk(NOP,0,0,0), 0, 0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;

    foreach (rows[i]) begin
      applyStimulus(rows[i].vin, rows[i].hold, rows[i].flush);
      #1;
      check($sformatf("tbl%0d_stall", i), 32'(stall_o), 32'(rows[i].stall));
      check($sformatf("tbl%0d_fwd", i), 32'({ForwardA_o, ForwardB_o}), 32'({rows[i].fa, rows[i].fb}));
      check($sformatf("tbl%0d_ex_wreg", i), 32'(ex_wreg_o), 32'(rows[i].ex_wreg));
      check($sformatf("tbl%0d_mem_mw", i), 32'(mem_MemWrite_o), 32'(rows[i].mem_mw));
      check($sformatf("tbl%0d_wb", i), 32'({wb_RegWrite_o, wb_wreg_o}), 32'({rows[i].wb_rw, rows[i].wb_wreg}));
      check($sformatf("tbl%0d_retired", i), 32'(retired_o), 32'(rows[i].ret));
      cycle();
    end

    keep = 1'b0;
    v = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
      end
      if (!keep)
        v = ($urandom_range(0, 99) < 80) ?
            mk(int'($urandom_range(1, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7))) : mk(NOP, 0, 0, 0);
      applyStimulus(v, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
      keep = model_stall() || cur_hold;
      cycle();
    end

    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(mk(ADD, 1, 2, 3), 0, 0);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(NOP, 0, 0, 0), 0, 0);
      cycle();
    end
    #1 check("wrap_retired", 32'(retired_o), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumes the decoded control bundle and register fields produced in ID.
- Carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards (stall request, bubble insertion) and generates EX-stage forwarding selects.
- Counts retired instructions.
- Sits between the control decoder/register-field extraction and the datapath muxes of EX, MEM and WB.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
hold_i  in  1  global freeze (memory wait); all pipeline registers and the counter keep their value
flush_i  in  1  branch/jump taken in ID; bubble into ID/EX
valid_i  in  1  ID holds a real instruction
RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  decoded controls
ALUOp_i  in  2  decoded ALU op class
rs_i, rt_i, rd_i  in  5 each  ID register fields
stall_o  out  1  load-use stall: PC and IF/ID must hold
ex_RegDst_o, ex_ALUSrc_o  out  1 each  EX controls (ID/EX)
ex_ALUOp_o  out  2  EX ALU op class
ex_rs_o, ex_rt_o, ex_wreg_o  out  5 each  EX register fields; wreg = RegDst ? rd : rt
ForwardA_o, ForwardB_o  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
mem_MemRead_o, mem_MemWrite_o  out  1 each  MEM controls (EX/MEM)
mem_wreg_o  out  5  EX/MEM destination
wb_RegWrite_o, wb_MemtoReg_o  out  1 each  WB controls (MEM/WB)
wb_wreg_o  out  5  MEM/WB destination
retired_o  out  CNT_W  retired instruction count

Behaviour:
- Reset: asynchronous on rst_i=0. Every register, every output and all stage valid bits go to 0; retired_o=0.
- Each stage register holds a valid bit plus its fields.
- A bubble loads valid=0 and zeros all controls and register fields.
- Per rising edge, priority: hold_i=1 > bubble > advance.
  - hold_i=1: ID/EX, EX/MEM, MEM/WB and the counter all keep their values. A flush_i asserted during hold is ignored; its source must keep it asserted until hold drops.
  - Bubble: applied when stall_o=1 or flush_i=1 or valid_i=0. ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
  - Advance: ID/EX loads the inputs with valid=1 and wreg = RegDst_i ? rd_i : rt_i. EX/MEM takes MemRead, MemWrite, RegWrite, MemtoReg, wreg and valid from ID/EX. MEM/WB takes RegWrite, MemtoReg, wreg and valid from EX/MEM.
- Latency: an ID input appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later, absent hold/bubble.
- stall_o is combinational and evaluated irrespective of hold_i:
  - stall_o = 1 iff ID/EX valid & ID/EX MemRead & ex_rt != 0 & valid_i & (ex_rt == rs_i | ex_rt == rt_i).
  - The stall lasts exactly one cycle, because the bubble clears ID/EX MemRead.
- ForwardA_o is combinational, evaluated on ex_rs:
  - 10 if EX/MEM valid & RegWrite & mem_wreg != 0 & mem_wreg == ex_rs;
  - else 01 if MEM/WB valid & RegWrite & wb_wreg != 0 & wb_wreg == ex_rs;
  - else 00.
  - EX/MEM wins when both stages match.
- ForwardB_o: same rules applied to ex_rt.
- Register $0 is never forwarded or stalled on.
- Counter: on an edge with hold_i=0 and MEM/WB valid=1, retired_o increments by 1. It wraps from 2^CNT_W-1 to 0 silently.
- Simultaneous stall_o and flush_i: a single bubble; no double effect.
- Reset asserted mid-operation: all in-flight state is discarded immediately, without waiting for a clock edge.

Test Plan:
- Reset/latency: apply rst_i=0 mid-stream → all outputs 0 without a clock edge. Release reset, then issue add (RegDst=1, RegWrite=1, ALUOp=11, rd=8) → ex_wreg_o=8 at +1, wb_RegWrite_o=1 and wb_wreg_o=8 at +3, retired_o=1 at +4.
- Load-use: lw rt=9 followed by add rs=9 → stall_o=1 for exactly one cycle. ID/EX then holds a bubble (ex_ALUOp_o=00, ex_wreg_o=0). When the add reaches EX, ForwardA_o=01.
- Forward priority: add → $5, add → $5, then add rs=5 rt=5 → ForwardA_o=ForwardB_o=10. Repeat with a destination of $0 instead → both 00.
- Flush and hold: flush_i=1 on a valid sw → mem_MemWrite_o stays 0 and retired_o does not count it. Assert hold_i=1 for 3 cycles with sw in EX/MEM → mem_MemWrite_o=1 stays constant and retired_o is frozen.
- Simultaneous stall + flush: assert both in the same cycle → exactly one bubble, and the next instruction enters ID/EX on the following edge.
- Counter wrap: with CNT_W=4, retire 17 instructions → retired_o=1.
